// File: rtl/hll_pkg.sv
// rtl/hll_pkg.sv - shared state encoding and helper functions for HLL cell variants
package hll_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_REFRACT = 2'd2
  } hll_state_e;

  // Widest hash word the leading-zero counter handles
  localparam int LZC_MAX_W = 256;

  function automatic int hll_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Leading zeros of the low 'width' bits of word; returns width when all zero
  function automatic int hll_lzc(input logic [LZC_MAX_W-1:0] word, input int width);
    int   zeros;
    logic found;
    zeros = 0;
    found = 1'b0;
    for (int i = LZC_MAX_W - 1; i >= 0; i--) begin
      if ((i < width) && !found) begin
        if (word[i]) found = 1'b1;
        else         zeros = zeros + 1;
      end
    end
    return zeros;
  endfunction

endpackage

// File: rtl/hll_popcount.sv
// rtl/hll_popcount.sv - registered population count of the touch bitmap, 1-cycle latency
module hll_popcount
  import hll_pkg::*;
#(
  parameter int IN_DEGREE = 256,
  parameter int CNT_W     = hll_clog2(IN_DEGREE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic [IN_DEGREE-1:0] bits,
  output logic [CNT_W-1:0]     count
);

  logic [CNT_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < IN_DEGREE; i++) begin
      sum = sum + CNT_W'(bits[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else          count <= sum;
  end

endmodule

// File: rtl/hll_cell_fsm.sv
// rtl/hll_cell_fsm.sv - HLL neuron cell: sticky touch bitmap wake-up, rank absorb, timed phases
// Optional accumulation window enabled by defining HLL_CELL_WINDOW_EN.
module hll_cell_fsm
  import hll_pkg::*;
#(
  parameter int  HASH_WIDTH     = 64,
  parameter int  IN_DEGREE      = 256,
  parameter int  HOLD_CYCLES    = 64,
  parameter int  REFRACT_CYCLES = 16,
  parameter int  WINDOW_CYCLES  = 1024,
  localparam int CNT_W          = hll_clog2(IN_DEGREE + 1),
  localparam int RANK_W         = hll_clog2(HASH_WIDTH + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_DEGREE-1:0]  touch_attempts,
  input  logic [CNT_W-1:0]      thresh,
  input  logic                  force_sleep,
  input  logic                  rank_clr,
  input  logic                  hash_valid,
  output logic                  hash_ready,
  input  logic [HASH_WIDTH-1:0] hash_data,
  output logic                  active,
  output logic                  wake_pulse,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      touch_count,
  output logic [RANK_W-1:0]     rank
);

  localparam int TMR_MAX = (HOLD_CYCLES > REFRACT_CYCLES) ? HOLD_CYCLES : REFRACT_CYCLES;
  localparam int TMR_W   = (hll_clog2(TMR_MAX + 1) < 1) ? 1 : hll_clog2(TMR_MAX + 1);

  hll_state_e          state_q, state_n;
  logic [IN_DEGREE-1:0] bitmap_q, bitmap_n;
  logic [TMR_W-1:0]    timer_q, timer_n;
  logic [RANK_W-1:0]   rank_q, rank_n, hash_rank;
  logic                wake_q, wake_n;
  logic                cnt_clr;
  logic                accept;
  logic [CNT_W-1:0]    thresh_eff;

`ifdef HLL_CELL_WINDOW_EN
  localparam int WIN_W = (hll_clog2(WINDOW_CYCLES) < 1) ? 1 : hll_clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  logic [WIN_W-1:0] win_q, win_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) win_q <= '0;
    else       win_q <= win_n;
  end
`else
  logic unused_window;
  assign unused_window = (WINDOW_CYCLES != 0);
`endif

  assign thresh_eff = (thresh == '0) ? CNT_W'(1) : thresh;
  assign accept     = hash_valid && (state_q == ST_ACTIVE);
  assign hash_rank  = RANK_W'(hll_lzc(LZC_MAX_W'(hash_data), HASH_WIDTH) + 1);

  hll_popcount #(
    .IN_DEGREE (IN_DEGREE),
    .CNT_W     (CNT_W)
  ) u_popcount (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .bits  (bitmap_q),
    .count (touch_count)
  );

  always_comb begin
    state_n  = state_q;
    bitmap_n = bitmap_q;
    timer_n  = timer_q;
    rank_n   = rank_q;
    wake_n   = 1'b0;
    cnt_clr  = 1'b0;
`ifdef HLL_CELL_WINDOW_EN
    win_n    = win_q;
`endif

    // Rank is independent of phase changes; clear beats an accepted hash
    if (rank_clr)                              rank_n = '0;
    else if (accept && (hash_rank > rank_q))   rank_n = hash_rank;

    if (force_sleep) begin
      state_n  = ST_ACCUM;
      bitmap_n = '0;
      timer_n  = '0;
      cnt_clr  = 1'b1;
`ifdef HLL_CELL_WINDOW_EN
      win_n    = '0;
`endif
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (touch_count >= thresh_eff) begin
            state_n  = ST_ACTIVE;
            bitmap_n = '0;
            cnt_clr  = 1'b1;
            timer_n  = TMR_W'(HOLD_CYCLES);
            wake_n   = 1'b1;
`ifdef HLL_CELL_WINDOW_EN
            win_n    = '0;
`endif
          end else begin
            bitmap_n = bitmap_q | touch_attempts;
`ifdef HLL_CELL_WINDOW_EN
            if (bitmap_q != '0) begin
              if (win_q == WIN_LAST) begin
                bitmap_n = '0;
                cnt_clr  = 1'b1;
                win_n    = '0;
              end else begin
                win_n = win_q + 1'b1;
              end
            end
`endif
          end
        end
        ST_ACTIVE: begin
          // A zero hold keeps the cell awake until force_sleep
          if ((HOLD_CYCLES != 0) && (timer_q == TMR_W'(1))) begin
            if (REFRACT_CYCLES == 0) begin
              state_n = ST_ACCUM;
              timer_n = '0;
            end else begin
              state_n = ST_REFRACT;
              timer_n = TMR_W'(REFRACT_CYCLES);
            end
          end else if (timer_q != '0) begin
            timer_n = timer_q - 1'b1;
          end
        end
        ST_REFRACT: begin
          if (timer_q <= TMR_W'(1)) begin
            state_n = ST_ACCUM;
            timer_n = '0;
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
        default: begin
          state_n = ST_ACCUM;
          timer_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ACCUM;
      bitmap_q <= '0;
      timer_q  <= '0;
      rank_q   <= '0;
      wake_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      bitmap_q <= bitmap_n;
      timer_q  <= timer_n;
      rank_q   <= rank_n;
      wake_q   <= wake_n;
    end
  end

  assign state      = state_q;
  assign active     = (state_q == ST_ACTIVE);
  assign hash_ready = (state_q == ST_ACTIVE);
  assign wake_pulse = wake_q;
  assign rank       = rank_q;

endmodule

// File: tb/tb_hll_cell_fsm.sv
// tb/tb_hll_cell_fsm.sv - randomized and directed bench for hll_cell_fsm against a phase-level model
module tb_hll_cell_fsm;

  localparam int IN_DEGREE  = 8;
  localparam int HASH_WIDTH = 16;
  localparam int HOLD       = 4;
  localparam int REFRACT    = 2;
  localparam int WINDOW     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  touch_attempts;
  logic [3:0]  thresh;
  logic        force_sleep, rank_clr, hash_valid;
  logic [15:0] hash_data;
  logic        hash_ready, active, wake_pulse;
  logic [1:0]  state;
  logic [3:0]  touch_count;
  logic [4:0]  rank;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: phase plus absolute edge index at which the current timed phase ends
  int         m_state, m_count, m_rank, m_wake, m_end, m_k, m_wstart;
  logic [7:0] m_bits;
  int         act_cnt, ref_cnt;

  logic [7:0]  r_t;
  logic [15:0] r_h;

  hll_cell_fsm #(
    .HASH_WIDTH     (HASH_WIDTH),
    .IN_DEGREE      (IN_DEGREE),
    .HOLD_CYCLES    (HOLD),
    .REFRACT_CYCLES (REFRACT),
    .WINDOW_CYCLES  (WINDOW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .touch_attempts (touch_attempts),
    .thresh         (thresh),
    .force_sleep    (force_sleep),
    .rank_clr       (rank_clr),
    .hash_valid     (hash_valid),
    .hash_ready     (hash_ready),
    .hash_data      (hash_data),
    .active         (active),
    .wake_pulse     (wake_pulse),
    .state          (state),
    .touch_count    (touch_count),
    .rank           (rank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_rank(input logic [15:0] h);
    int r;
    r = HASH_WIDTH + 1;
    for (int i = 0; i < HASH_WIDTH; i++) begin
      if (h[i]) r = HASH_WIDTH - i;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_bits = '0; m_count = 0; m_rank = 0;
    m_wake = 0; m_end = 0; m_k = 0; m_wstart = 0;
  endtask

  task automatic model_step(input logic [7:0] t, input bit fs, input bit rc,
                            input bit hv, input logic [15:0] hd, input int th);
    int         thr, r;
    logic [7:0] old_bits;
    m_k++;
    r = model_rank(hd);
    if (rc) m_rank = 0;
    else if (hv && (m_state == 1) && (r > m_rank)) m_rank = r;
    thr      = (th == 0) ? 1 : th;
    m_wake   = 0;
    old_bits = m_bits;
    if (fs) begin
      m_state = 0; m_bits = '0; m_count = 0;
    end else if (m_state == 0) begin
      if (m_count >= thr) begin
        m_state = 1; m_bits = '0; m_count = 0; m_wake = 1; m_end = m_k + HOLD;
      end else begin
`ifdef HLL_CELL_WINDOW_EN
        if ((old_bits != 0) && (m_k == m_wstart + WINDOW)) begin
          m_bits = '0; m_count = 0;
        end else begin
          m_count = $countones(old_bits);
          m_bits  = old_bits | t;
          if ((old_bits == 0) && (m_bits != 0)) m_wstart = m_k;
        end
`else
        m_count = $countones(old_bits);
        m_bits  = old_bits | t;
`endif
      end
    end else if (m_state == 1) begin
      if ((HOLD != 0) && (m_k == m_end)) begin
        if (REFRACT == 0) m_state = 0;
        else begin m_state = 2; m_end = m_k + REFRACT; end
      end
    end else begin
      if (m_k == m_end) m_state = 0;
    end
  endtask

  task automatic step(input logic [7:0] t, input bit fs, input bit rc,
                      input bit hv, input logic [15:0] hd);
    touch_attempts = t; force_sleep = fs; rank_clr = rc; hash_valid = hv; hash_data = hd;
    @(posedge clk);
    model_step(t, fs, rc, hv, hd, int'(thresh));
    @(negedge clk);
  endtask

  task automatic idle();
    step(8'h00, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",       int'(state),       m_state);
      check("active",      int'(active),      (m_state == 1) ? 1 : 0);
      check("hash_ready",  int'(hash_ready),  (m_state == 1) ? 1 : 0);
      check("wake_pulse",  int'(wake_pulse),  m_wake);
      check("touch_count", int'(touch_count), m_count);
      check("rank",        int'(rank),        m_rank);
    end
  end

  initial begin
    touch_attempts = '0; thresh = '0; force_sleep = 1'b0; rank_clr = 1'b0;
    hash_valid = 1'b0; hash_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_active", int'(active), 0);
    check("rst_hash_ready", int'(hash_ready), 0);
    check("rst_wake", int'(wake_pulse), 0);
    check("rst_count", int'(touch_count), 0);
    check("rst_rank", int'(rank), 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Wake timing with three single-bit touches
    thresh = 4'd3;
    step(8'h01, 0, 0, 0, 16'h0);
    step(8'h02, 0, 0, 0, 16'h0);
    step(8'h04, 0, 0, 0, 16'h0);
    check("t1_no_early_wake", int'(active), 0);
    idle();
    check("t1_count3", int'(touch_count), 3);
    check("t1_still_asleep", int'(active), 0);
    idle();
    check("t1_active", int'(active), 1);
    check("t1_wake_pulse", int'(wake_pulse), 1);
    check("t1_count_clr", int'(touch_count), 0);

    // Phase durations, touches ignored while awake or refractory
    act_cnt = 1; ref_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(8'hFF, 0, 0, 0, 16'h0);
      if (i == 0) check("t2_pulse_one_cycle", int'(wake_pulse), 0);
      if (active) act_cnt++;
      if (state == 2'd2) ref_cnt++;
      check("t2_touch_ignored", int'(touch_count), 0);
    end
    check("t2_active_cycles", act_cnt, 4);
    check("t2_refract_cycles", ref_cnt, 2);
    check("t2_back_accum", int'(state), 0);
    idle();
    check("t2_bitmap_empty", int'(touch_count), 0);

    // Rank absorption and rank_clr priority
    thresh = 4'd1;
    step(8'h01, 0, 0, 0, 16'h0);
    idle(); idle();
    check("t3_active", int'(active), 1);
    step(8'h00, 0, 0, 1, 16'h0F00);
    check("t3_rank_0f00", int'(rank), 5);
    step(8'h00, 0, 0, 1, 16'h8000);
    check("t3_rank_8000", int'(rank), 5);
    step(8'h00, 0, 0, 1, 16'h0000);
    check("t3_rank_zero", int'(rank), 17);
    step(8'h00, 0, 1, 1, 16'h8000);
    check("t3_rank_clr", int'(rank), 0);
    idle(); idle();
    check("t3_accum", int'(state), 0);

    // Threshold zero acts as one; threshold above IN_DEGREE never wakes
    thresh = 4'd0;
    step(8'h10, 0, 0, 0, 16'h0);
    idle(); idle();
    check("t4_thresh0_wake", int'(active), 1);
    repeat (6) idle();
    check("t4_accum", int'(state), 0);
    thresh = 4'd9;
    step(8'hFF, 0, 0, 0, 16'h0);
    repeat (4) idle();
    check("t4_count8", int'(touch_count), 8);
    check("t4_no_wake", int'(active), 0);
    step(8'h00, 1, 0, 0, 16'h0);
    check("t4_fs_clears", int'(touch_count), 0);

    // force_sleep mid-ACTIVE, then async reset mid-REFRACT
    thresh = 4'd1;
    step(8'h01, 0, 0, 0, 16'h0);
    idle(); idle();
    check("t5_active", int'(active), 1);
    step(8'h00, 0, 0, 1, 16'h0100);
    check("t5_rank8", int'(rank), 8);
    step(8'h00, 1, 0, 1, 16'h0001);
    check("t5_fs_state", int'(state), 0);
    check("t5_fs_ready", int'(hash_ready), 0);
    check("t5_fs_rank", int'(rank), 16);
    step(8'h01, 0, 0, 0, 16'h0);
    idle(); idle();
    repeat (4) idle();
    check("t5_refract", int'(state), 2);
    #2 reset = 1'b1;
    #1;
    check("t5_arst_state", int'(state), 0);
    check("t5_arst_active", int'(active), 0);
    check("t5_arst_ready", int'(hash_ready), 0);
    check("t5_arst_wake", int'(wake_pulse), 0);
    check("t5_arst_count", int'(touch_count), 0);
    check("t5_arst_rank", int'(rank), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Accumulation window behaviour
    thresh = 4'd4;
    step(8'h03, 0, 0, 0, 16'h0);
    repeat (4) idle();
    check("t6_count2", int'(touch_count), 2);
    repeat (5) idle();
`ifdef HLL_CELL_WINDOW_EN
    check("t6_window_clear", int'(touch_count), 0);
`else
    check("t6_no_window_hold", int'(touch_count), 2);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) thresh = 4'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0:       r_t = 8'(1 << $urandom_range(0, 7));
        1:       r_t = 8'($urandom);
        default: r_t = 8'h00;
      endcase
      r_h = 16'($urandom >> $urandom_range(0, 16));
      step(r_t, ($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 1) == 1), r_h);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
